// File: rtl/alu_accum_param.sv
// Parametrised accumulator ALU: one operation per accepted request, iterative
// shift-add multiply, status flags and optional unsigned saturation.
//
// state  | meaning
// IDLE   | in_ready high; single-cycle ops complete on the accepting edge
// MUL    | shift-add multiply in progress, one multiplier bit per edge
module alu_accum_param #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_LOAD = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_step;
  logic               prod_hi;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, operand};
    diff      = {1'b0, acc_q} - {1'b0, operand};
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_hi   = |prod_step[2*WIDTH-1:WIDTH];

    state_d  = state_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    if (state_q == S_IDLE) begin
      if (in_valid) begin
        valid_d = 1'b1;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (operation)
          OP_ADD: begin
            carry_d = sum[WIDTH];
            ovf_d   = (acc_q[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
            acc_d   = (SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
          end
          OP_SUB: begin
            carry_d = diff[WIDTH];
            ovf_d   = (acc_q[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
            acc_d   = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
          end
          OP_OR:   acc_d = acc_q | operand;
          OP_XOR:  acc_d = acc_q ^ operand;
          OP_AND:  acc_d = acc_q & operand;
          OP_LOAD: acc_d = operand;
          OP_CLR:  acc_d = '0;
          OP_MUL: begin
            // flags and result stay untouched until the product is done
            valid_d  = 1'b0;
            carry_d  = carry_q;
            ovf_d    = ovf_q;
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = operand;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end
          default: acc_d = acc_q;
        endcase
        zero_d = (acc_d == '0);
      end
    end else begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        carry_d = prod_hi;
        ovf_d   = 1'b0;
        acc_d   = (SATURATE && prod_hi) ? '1 : prod_step[WIDTH-1:0];
        zero_d  = (acc_d == '0);
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign result       = acc_q;
  assign result_valid = valid_q;
  assign flag_zero    = zero_q;
  assign flag_carry   = carry_q;
  assign flag_ovf     = ovf_q;

endmodule

// File: tb/tb_alu_accum_param.sv
// Bench for alu_accum_param: a wrapping and a saturating instance share stimulus;
// expected results are queued at request time and checked on result_valid.
module tb_alu_accum_param;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       in_valid;
  logic [2:0] operation;
  logic [7:0] operand;

  logic       in_ready0, in_ready1;
  logic [7:0] result0, result1;
  logic       rv0, rv1, z0, z1, c0, c1, v0, v1;

  always #5 clock = ~clock;

  alu_accum_param #(.WIDTH(8), .SATURATE(1'b0)) dut0 (
    .clock(clock), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready0),
    .operation(operation), .operand(operand), .result(result0), .result_valid(rv0),
    .flag_zero(z0), .flag_carry(c0), .flag_ovf(v0)
  );

  alu_accum_param #(.WIDTH(8), .SATURATE(1'b1)) dut1 (
    .clock(clock), .reset_L(reset_L), .in_valid(in_valid), .in_ready(in_ready1),
    .operation(operation), .operand(operand), .result(result1), .result_valid(rv1),
    .flag_zero(z1), .flag_carry(c1), .flag_ovf(v1)
  );

  typedef struct {
    logic [7:0] r0;
    logic       c0;
    logic       v0;
    logic [7:0] r1;
    logic       c1;
    logic       v1;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[19];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   pushed = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (rv0 || rv1) begin
      chk("valid_match", rv1, rv0);
      pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("result_wrap", result0, e.r0);
        chk("carry_wrap", c0, e.c0);
        chk("ovf_wrap", v0, e.v0);
        chk("zero_wrap", z0, e.r0 == 8'd0);
        chk("result_sat", result1, e.r1);
        chk("carry_sat", c1, e.c1);
        chk("ovf_sat", v1, e.v1);
        chk("zero_sat", z1, e.r1 == 8'd0);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [7:0] d, input bit push, input exp_t e);
    int n = 0;
    @(negedge clock);
    in_valid  = 1'b1;
    operation = op;
    operand   = d;
    while (!in_ready0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("accept_timeout", in_ready0, 1);
    if (push) begin
      sb_q.push_back(e);
      pushed++;
    end
    @(posedge clock);
    #1;
    last_acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] d,
                              input logic [7:0] r0, input logic c0_, input logic v0_,
                              input logic [7:0] r1, input logic c1_, input logic v1_);
    vec_t v;
    v.op = op; v.d = d;
    v.e.r0 = r0; v.e.c0 = c0_; v.e.v0 = v0_;
    v.e.r1 = r1; v.e.c1 = c1_; v.e.v1 = v1_;
    return v;
  endfunction

  initial begin
    exp_t e;
    logic [7:0] prev0, prev1;
    int n;
    int mul_cyc;

    vecs[0]  = mk(3'd5, 8'd200,  8'd200, 0, 0, 8'd200, 0, 0);
    vecs[1]  = mk(3'd0, 8'd100,  8'd44,  1, 0, 8'd255, 1, 0);
    vecs[2]  = mk(3'd5, 8'd100,  8'd100, 0, 0, 8'd100, 0, 0);
    vecs[3]  = mk(3'd0, 8'd100,  8'd200, 0, 1, 8'd200, 0, 1);
    vecs[4]  = mk(3'd7, 8'd0,    8'd0,   0, 0, 8'd0,   0, 0);
    vecs[5]  = mk(3'd1, 8'd1,    8'd255, 1, 0, 8'd0,   1, 0);
    vecs[6]  = mk(3'd5, 8'hF0,   8'hF0,  0, 0, 8'hF0,  0, 0);
    vecs[7]  = mk(3'd2, 8'h0F,   8'hFF,  0, 0, 8'hFF,  0, 0);
    vecs[8]  = mk(3'd3, 8'hFF,   8'h00,  0, 0, 8'h00,  0, 0);
    vecs[9]  = mk(3'd5, 8'h3C,   8'h3C,  0, 0, 8'h3C,  0, 0);
    vecs[10] = mk(3'd4, 8'h0F,   8'h0C,  0, 0, 8'h0C,  0, 0);
    vecs[11] = mk(3'd5, 8'd15,   8'd15,  0, 0, 8'd15,  0, 0);
    vecs[12] = mk(3'd6, 8'd20,   8'd44,  1, 0, 8'd255, 1, 0);
    vecs[13] = mk(3'd5, 8'd12,   8'd12,  0, 0, 8'd12,  0, 0);
    vecs[14] = mk(3'd6, 8'd10,   8'd120, 0, 0, 8'd120, 0, 0);
    vecs[15] = mk(3'd5, 8'h80,   8'h80,  0, 0, 8'h80,  0, 0);
    vecs[16] = mk(3'd1, 8'd1,    8'h7F,  0, 1, 8'h7F,  0, 1);
    vecs[17] = mk(3'd0, 8'h81,   8'h00,  1, 0, 8'hFF,  1, 0);
    vecs[18] = mk(3'd6, 8'd3,    8'd0,   0, 0, 8'd255, 1, 0);

    // reset with a request present: nothing may be accepted
    reset_L   = 1'b0;
    in_valid  = 1'b1;
    operation = 3'd0;
    operand   = 8'd5;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_result0", result0, 0);
    chk("rst_result1", result1, 0);
    chk("rst_zero", z0, 1);
    chk("rst_carry_ovf", {c0, v0}, 0);
    chk("rst_valid", rv0, 0);
    chk("rst_ready", in_ready0, 1);
    in_valid = 1'b0;
    reset_L  = 1'b1;

    prev0 = 8'd0;
    prev1 = 8'd0;
    for (int i = 0; i < 19; i++) begin
      do_op(vecs[i].op, vecs[i].d, 1'b1, vecs[i].e);
      if (vecs[i].op == 3'd6) begin
        n = 0;
        @(negedge clock);
        chk("mul_hold0", result0, prev0);
        chk("mul_hold1", result1, prev1);
        while (!in_ready0 && n < 50) begin
          n++;
          @(negedge clock);
        end
        chk("mul_busy_cycles", n, 8);
      end
      prev0 = vecs[i].e.r0;
      prev1 = vecs[i].e.r1;
    end

    // request held during a multiply is taken only once in_ready returns
    e = '{r0: 8'd3, c0: 0, v0: 0, r1: 8'd3, c1: 0, v1: 0};
    do_op(3'd5, 8'd3, 1'b1, e);
    e = '{r0: 8'd15, c0: 0, v0: 0, r1: 8'd15, c1: 0, v1: 0};
    do_op(3'd6, 8'd5, 1'b1, e);
    mul_cyc = last_acc_cyc;
    e = '{r0: 8'd16, c0: 0, v0: 0, r1: 8'd16, c1: 0, v1: 0};
    do_op(3'd0, 8'd1, 1'b1, e);
    chk("held_accept_delay", last_acc_cyc - mul_cyc, 9);

    // reset mid-multiply aborts without a completion pulse
    e = '{r0: 8'd7, c0: 0, v0: 0, r1: 8'd7, c1: 0, v1: 0};
    do_op(3'd5, 8'd7, 1'b1, e);
    do_op(3'd6, 8'd9, 1'b0, e);
    repeat (3) @(negedge clock);
    reset_L = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    chk("abort_result0", result0, 0);
    chk("abort_result1", result1, 0);
    chk("abort_ready", in_ready0, 1);
    chk("abort_zero", z0, 1);
    repeat (12) @(negedge clock);
    chk("abort_ready_after", in_ready1, 1);

    chk("scoreboard_empty", sb_q.size(), 0);
    chk("pulse_count", pulses, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_accum_param.md
Name: alu_accum_param

Overview:
- Parametrised accumulator ALU: next generation of the team's 4-bit accumulate-and-operate block.
- Holds a WIDTH-bit accumulator and applies one operation per accepted request against an input operand.
- Adds a valid/ready request handshake, an iterative multi-cycle multiply, status flags, an optional saturating mode and a one-cycle completion strobe.
- Sits as a small datapath engine behind a control FSM or pin-level demo wrapper.

Parameters:
- WIDTH, 8, accumulator/operand/result width in bits (>=2).
- SATURATE, 0, 1 = ADD/SUB/MUL clamp unsigned to range instead of wrapping.

Ports:
- clock  input  1  sole clock, all state updates on rising edge.
- reset_L  input  1  synchronous, active-low reset, sampled on rising edge of clock.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- operation  input  3  opcode, sampled when in_valid && in_ready.
- operand  input  WIDTH  operand, sampled with operation.
- result  output  WIDTH  current accumulator value (registered).
- result_valid  output  1  one-cycle pulse: an operation completed and result/flags were updated.
- flag_zero  output  1  result == 0 (registered with result).
- flag_carry  output  1  unsigned carry/borrow/product-overflow of last completed op.
- flag_ovf  output  1  signed overflow of last completed ADD/SUB.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-low (reset_L).
- Reset values: result=0, flag_zero=1, flag_carry=0, flag_ovf=0, result_valid=0, in_ready=1, FSM=IDLE, multiply counter/registers cleared.
- Reset asserted mid-multiply aborts the multiply; no result_valid pulse is produced.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. operation/operand are ignored at all other times.
- FSM states are IDLE and MUL. in_ready = (state == IDLE).
- Opcodes 0 to 5 and 7 complete in one cycle. At the accepting edge, result and all flags update and result_valid=1 for the following cycle.
  - 0 ADD: sum = acc + operand, WIDTH+1 bits. carry = sum[WIDTH]. ovf = both inputs share a sign bit and the result sign differs.
  - 1 SUB: acc - operand. carry = borrow (operand > acc unsigned). ovf = operand signs differ and the result sign differs from acc.
  - 2 OR, 3 XOR, 4 AND: bitwise. carry=0, ovf=0.
  - 5 LOAD: acc = operand. carry=0, ovf=0.
  - 7 CLR: acc = 0. carry=0, ovf=0.
- Opcode 6 MUL: iterative shift-add. Computes the low WIDTH bits of acc*operand (unsigned).
  - Accepting edge T: latch multiplicand=acc, multiplier=operand, clear the 2*WIDTH product, set counter=0, enter MUL. in_ready drops.
  - Each edge in MUL processes one multiplier bit. After WIDTH iterations (edge T+WIDTH): write result, flags, result_valid=1, return to IDLE.
  - in_ready is low for exactly WIDTH cycles. A new request can be accepted at edge T+WIDTH+1.
  - carry = any product bit above WIDTH-1 is set. ovf=0.
  - result holds its old value during MUL.
- SATURATE=1:
  - ADD with carry gives all-ones.
  - SUB with borrow gives 0.
  - MUL with carry gives all-ones.
  - Flags still report the unsaturated carry. ovf is still computed on the wrapped value.
- flag_zero always reflects the written result, including the saturated value.
- result_valid is high for exactly one cycle per completed op. Back-to-back single-cycle ops give consecutive pulses.
- in_valid held high while in_ready=0 has no effect; the request is taken when in_ready returns.

Test Plan:
- Reset: WIDTH=8. Hold reset_L=0 for 2 edges with in_valid=1 ADD 5 -> result=0, flag_zero=1, result_valid=0, in_ready=1.
- Wrap vs saturate:
  - LOAD 200, then ADD 100 with SATURATE=0 -> result=44, carry=1, ovf=0.
  - LOAD 100, ADD 100 -> 200, carry=0, ovf=1.
  - With SATURATE=1, LOAD 200, ADD 100 -> 255, carry=1.
- Borrow: CLR, SUB 1 -> 255, carry=1, ovf=0, zero=0. Same with SATURATE=1 -> 0, zero=1, carry=1.
- Logic ops: LOAD 0xF0, OR 0x0F -> 0xFF; XOR 0xFF -> 0x00, zero=1; AND after LOAD 0x3C with 0x0F -> 0x0C. One result_valid pulse per op.
- Multiply:
  - LOAD 15, MUL 20 -> in_ready low 8 cycles, then result=44, carry=1, single result_valid pulse.
  - A request held on in_valid during busy is accepted only after in_ready rises.
  - LOAD 12, MUL 10 -> 120, carry=0.
- Abort: LOAD 7, MUL 9; pull reset_L low 3 cycles into MUL -> result=0, IDLE, in_ready=1, no result_valid pulse.
